if_id_stall_ctrl: RTL and testbench

IF_ID_STALL_CTRL -- requirements
Module: if_id_stall_ctrl

---
 rtl/if_id_stall_ctrl_pkg.sv | 27 ++
 rtl/if_id_stall_ctrl_dff_en.sv | 33 +++
 rtl/if_id_stall_ctrl.sv | 151 +++++++++++++++
 tb/tb_if_id_stall_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stall_ctrl_pkg
// Description : Shared constants and FSM state encoding for the IF/ID
//               stall/flush/halt controller and the stages around it.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_stall_ctrl_pkg;

  // Instruction word used as a bubble (opcode 00001).
  localparam logic [15:0] c_NOP_INSTR = 16'h0800;
  // Opcode that stops instruction fetch.
  localparam logic [4:0]  c_HALT_OPC  = 5'b00000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  // Opcode field of a 16-bit instruction word.
  function automatic logic [4:0] opcode_of(input logic [15:0] instr);
    return instr[15:11];
  endfunction

endpackage : if_id_stall_ctrl_pkg
`default_nettype wire

// File: rtl/if_id_stall_ctrl_dff_en.sv
`default_nettype none
// ============================================================================
// Module      : dff_en
// Description : Width-parameterised register with enable and asynchronous
//               active-low reset to a parameterised value.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_en #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Capture d when enabled, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : dff_en
`default_nettype wire

// File: rtl/if_id_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stall_ctrl
// Description : IF/ID pipeline register control. Handles hazard stalls,
//               branch squashes and the halt instruction, and drives the PC
//               write enable and the ID/EX bubble request.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stall_ctrl
  import if_id_stall_ctrl_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = c_NOP_INSTR,
  parameter logic [4:0]  HALT_OPC  = c_HALT_OPC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc2_in,
  output logic [15:0] instr_out,
  output logic [15:0] pc2_out,
  output logic        ifid_valid,
  output logic        pc_wr_en,
  output logic        idex_bubble,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_ifid_valid;
  logic        r_halted;
  logic [15:0] r_stall_cnt;

  logic [15:0] w_instr_q;
  logic [15:0] w_pc2_q;
  logic        w_active;
  logic        w_halt_hit;
  logic        w_instr_en;
  logic [15:0] w_instr_d;
  logic        w_pc2_en;
  logic        w_cnt_inc;
  logic        w_pc_wr_en;
  logic        w_idex_bubble;

  // Next-state decode and the combinational pipeline controls.
  always_comb begin
    w_next_state  = r_state;
    w_active      = 1'b0;
    w_halt_hit    = 1'b0;
    w_pc_wr_en    = 1'b0;
    w_idex_bubble = 1'b1;
    case (r_state)
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_active      = 1'b1;
        // A halt only takes effect when it would otherwise advance; a flush
        // squashes it first.
        w_halt_hit    = r_ifid_valid && (opcode_of(w_instr_q) == HALT_OPC)
                        && !stall && !flush;
        w_pc_wr_en    = flush || !stall;
        w_idex_bubble = stall && !flush;
        if (flush) begin
          w_next_state = ST_RUN;
        end else if (stall) begin
          w_next_state = ST_STALL;
        end else if (w_halt_hit) begin
          w_next_state = ST_HALT;
        end else begin
          w_next_state = ST_RUN;
        end
      end
    endcase
  end

  // Instruction register loads on advance or squash; a squash or halt
  // entry replaces the word with a NOP.
  assign w_instr_en = w_active && (flush || !stall);
  assign w_instr_d  = (flush || w_halt_hit) ? NOP_INSTR : instr_in;
  // PC+2 only follows a real advance; a squash leaves it untouched.
  assign w_pc2_en   = w_active && !flush && !stall;
  assign w_cnt_inc  = w_active && stall && !flush;

  dff_en #(
    .WIDTH   (16),
    .RST_VAL (NOP_INSTR)
  ) u_instr_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_instr_en),
    .d     (w_instr_d),
    .q     (w_instr_q)
  );

  dff_en #(
    .WIDTH   (16),
    .RST_VAL (16'h0000)
  ) u_pc2_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_pc2_en),
    .d     (pc2_in),
    .q     (w_pc2_q)
  );

  // FSM state register; halted mirrors the HALT state as a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_halted <= (w_next_state == ST_HALT);
    end
  end

  // Valid bit: cleared by squash or halt entry, held through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_valid <= 1'b0;
    end else if (w_active) begin
      if (flush) begin
        r_ifid_valid <= 1'b0;
      end else if (!stall) begin
        r_ifid_valid <= !w_halt_hit;
      end
    end
  end

  // Saturating stalled-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_cnt_inc && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign instr_out   = w_instr_q;
  assign pc2_out     = w_pc2_q;
  assign ifid_valid  = r_ifid_valid;
  assign pc_wr_en    = w_pc_wr_en;
  assign idex_bubble = w_idex_bubble;
  assign halted      = r_halted;
  assign stall_cnt   = r_stall_cnt;

endmodule : if_id_stall_ctrl
`default_nettype wire

// File: tb/tb_if_id_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stall_ctrl
// Description : Self-checking bench for if_id_stall_ctrl: an abstract model
//               compared every cycle plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instr_in = 16'h1111;
  logic [15:0] pc2_in = 16'h0000;
  logic [15:0] instr_out;
  logic [15:0] pc2_out;
  logic        ifid_valid;
  logic        pc_wr_en;
  logic        idex_bubble;
  logic        halted;
  logic [15:0] stall_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  if_id_stall_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .instr_in    (instr_in),
    .pc2_in      (pc2_in),
    .instr_out   (instr_out),
    .pc2_out     (pc2_out),
    .ifid_valid  (ifid_valid),
    .pc_wr_en    (pc_wr_en),
    .idex_bubble (idex_bubble),
    .halted      (halted),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Abstract model of the IF/ID register contents.
  logic [15:0] m_instr  = 16'h0800;
  logic [15:0] m_pc2    = 16'h0000;
  logic [15:0] m_cnt    = 16'h0000;
  logic        m_valid  = 1'b0;
  logic        m_halted = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_instr  <= 16'h0800;
      m_pc2    <= 16'h0000;
      m_cnt    <= 16'h0000;
      m_valid  <= 1'b0;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (flush) begin
        m_instr <= 16'h0800;
        m_valid <= 1'b0;
      end else if (stall) begin
        m_cnt <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      end else if (m_valid && m_instr[15:11] == 5'b00000) begin
        m_instr  <= 16'h0800;
        m_valid  <= 1'b0;
        m_pc2    <= pc2_in;
        m_halted <= 1'b1;
      end else begin
        m_instr <= instr_in;
        m_pc2   <= pc2_in;
        m_valid <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_instr_out", instr_out, m_instr);
    check("cmp_pc2_out", pc2_out, m_pc2);
    check("cmp_ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
    check("cmp_stall_cnt", stall_cnt, m_cnt);
    check("cmp_halted", {15'd0, halted}, {15'd0, m_halted});
    check("cmp_pc_wr_en", {15'd0, pc_wr_en}, {15'd0, (!m_halted && (flush || !stall))});
    check("cmp_idex_bubble", {15'd0, idex_bubble}, {15'd0, (m_halted || (stall && !flush))});
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_instr", instr_out, 16'h0800);
    check("rst_pc2", pc2_out, 16'h0000);
    check("rst_valid", {15'd0, ifid_valid}, 16'd0);
    check("rst_cnt", stall_cnt, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_pc_wr_en", {15'd0, pc_wr_en}, 16'd1);
    check("rst_bubble", {15'd0, idex_bubble}, 16'd0);
    rst_n = 1'b1;

    // Normal advance
    instr_in = 16'hC123; pc2_in = 16'h0002;
    tick();
    check("adv_instr", instr_out, 16'hC123);
    check("adv_pc2", pc2_out, 16'h0002);
    check("adv_valid", {15'd0, ifid_valid}, 16'd1);

    // Two-cycle stall with changing input
    stall = 1'b1; instr_in = 16'hA001; pc2_in = 16'h0004;
    #1;
    check("stl1_pc_wr_en", {15'd0, pc_wr_en}, 16'd0);
    check("stl1_bubble", {15'd0, idex_bubble}, 16'd1);
    tick();
    check("stl1_instr", instr_out, 16'hC123);
    instr_in = 16'hA002;
    check("stl2_pc_wr_en", {15'd0, pc_wr_en}, 16'd0);
    check("stl2_bubble", {15'd0, idex_bubble}, 16'd1);
    tick();
    check("stl2_instr", instr_out, 16'hC123);
    check("stl2_pc2", pc2_out, 16'h0002);
    check("stl_cnt", stall_cnt, 16'd2);
    stall = 1'b0;
    tick();
    check("resume_instr", instr_out, 16'hA002);
    check("resume_pc2", pc2_out, 16'h0004);

    // Flush wins over stall
    stall = 1'b1; flush = 1'b1; instr_in = 16'hB0B0; pc2_in = 16'h0006;
    #1;
    check("fl_pc_wr_en", {15'd0, pc_wr_en}, 16'd1);
    check("fl_bubble", {15'd0, idex_bubble}, 16'd0);
    tick();
    check("fl_instr", instr_out, 16'h0800);
    check("fl_valid", {15'd0, ifid_valid}, 16'd0);
    check("fl_pc2", pc2_out, 16'h0004);
    check("fl_cnt", stall_cnt, 16'd2);

    // Halt squashed by flush does not halt
    stall = 1'b0; flush = 1'b0; instr_in = 16'h0000; pc2_in = 16'h0008;
    tick();
    check("hq_load", instr_out, 16'h0000);
    flush = 1'b1; instr_in = 16'hC0DE;
    tick();
    check("hq_halted", {15'd0, halted}, 16'd0);
    check("hq_instr", instr_out, 16'h0800);
    flush = 1'b0; instr_in = 16'h1234; pc2_in = 16'h000A;
    tick();
    check("hq_after", instr_out, 16'h1234);
    check("hq_after_halted", {15'd0, halted}, 16'd0);

    // Halt entry
    instr_in = 16'h0000; pc2_in = 16'h000C;
    tick();
    check("h_load_valid", {15'd0, ifid_valid}, 16'd1);
    instr_in = 16'h5555; pc2_in = 16'h000E;
    tick();
    check("h_halted", {15'd0, halted}, 16'd1);
    check("h_pc_wr_en", {15'd0, pc_wr_en}, 16'd0);
    check("h_bubble", {15'd0, idex_bubble}, 16'd1);
    check("h_instr", instr_out, 16'h0800);
    stall = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("h_frozen_instr", instr_out, 16'h0800);
    check("h_frozen_cnt", stall_cnt, 16'd2);
    check("h_still_halted", {15'd0, halted}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("h_rst_halted", {15'd0, halted}, 16'd0);
    tick();
    rst_n = 1'b1;

    // Saturation of the stall counter, then reset mid-stall
    instr_in = 16'h1357; pc2_in = 16'h0010;
    tick();
    stall = 1'b1;
    repeat (65534) tick();
    check("sat_fffe", stall_cnt, 16'hFFFE);
    repeat (3) tick();
    check("sat_ffff", stall_cnt, 16'hFFFF);
    rst_n = 1'b0;
    #1;
    check("mrst_instr", instr_out, 16'h0800);
    check("mrst_pc2", pc2_out, 16'h0000);
    check("mrst_valid", {15'd0, ifid_valid}, 16'd0);
    check("mrst_cnt", stall_cnt, 16'h0000);
    check("mrst_halted", {15'd0, halted}, 16'd0);
    stall = 1'b0;
    #1;
    check("mrst_pc_wr_en", {15'd0, pc_wr_en}, 16'd1);
    check("mrst_bubble", {15'd0, idex_bubble}, 16'd0);
    tick();
    rst_n = 1'b1;
    instr_in = 16'h2468; pc2_in = 16'h00AA;
    tick();
    check("post_rst_instr", instr_out, 16'h2468);
    check("post_rst_pc2", pc2_out, 16'h00AA);
    check("post_rst_valid", {15'd0, ifid_valid}, 16'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_if_id_stall_ctrl
`default_nettype wire
